// File: rtl/instr_mem_pipelined.sv
// instr_mem_pipelined: registered-read instruction memory with stall/flush,
// fault flagging and a streaming program-load port.
module instr_mem_pipelined #(
    parameter int          DATA_W   = 32,
    parameter int          ADDR_W   = 32,
    parameter int          DEPTH    = 1024,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_W-1:0]         fetch_addr,
    input  logic                      stall,
    input  logic                      flush,
    output logic [DATA_W-1:0]         instr_out,
    output logic                      instr_valid,
    output logic                      fault,
    input  logic                      prog_start,
    input  logic [$clog2(DEPTH)-1:0]  prog_base,
    input  logic                      prog_valid,
    input  logic [DATA_W-1:0]         prog_data,
    input  logic                      prog_last,
    output logic                      loading,
    output logic                      prog_err,
    output logic [$clog2(DEPTH):0]    prog_count
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic {RUN, LOAD} state_t;

    state_t              state_q, state_d;
    logic [IW:0]         ptr_q, ptr_d, cnt_q, cnt_d;
    logic                err_q, err_d, valid_q, valid_d, fault_q, fault_d, we;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [IW-1:0] idx;
    logic          bad;
    assign idx = fetch_addr[IW+1:2];
    assign bad = (|fetch_addr[1:0]) || (|fetch_addr[ADDR_W-1:IW+2]);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        instr_d = instr_q;
        valid_d = valid_q;
        fault_d = fault_q;
        we      = 1'b0;
        if (prog_start) begin
            // a start (or restart) swallows any beat offered in the same cycle
            state_d = LOAD;
            ptr_d   = {1'b0, prog_base};
            cnt_d   = '0;
            err_d   = 1'b0;
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            fault_d = 1'b0;
        end else if (state_q == LOAD) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            fault_d = 1'b0;
            if (prog_valid) begin
                // pointer saturates at DEPTH: beats past the end are dropped
                we      = !ptr_q[IW];
                ptr_d   = ptr_q[IW] ? ptr_q : ptr_q + 1'b1;
                cnt_d   = ptr_q[IW] ? cnt_q : cnt_q + 1'b1;
                err_d   = err_q | ptr_q[IW];
                state_d = prog_last ? RUN : LOAD;
            end
        end else if (flush) begin
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            fault_d = 1'b0;
        end else if (!stall) begin
            instr_d = bad ? NOP_WORD : mem[idx];
            valid_d = !bad;
            fault_d = bad;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            ptr_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[ptr_q[IW-1:0]] <= prog_data;
    end

    assign instr_out   = instr_q;
    assign instr_valid = valid_q;
    assign fault       = fault_q;
    assign loading     = (state_q == LOAD);
    assign prog_err    = err_q;
    assign prog_count  = cnt_q;
endmodule

// File: tb/tb_instr_mem_pipelined.sv
// tb_instr_mem_pipelined: directed tests for instr_mem_pipelined with a
// 16-word memory; each task checks its own expected values inline.
module tb_instr_mem_pipelined;
    localparam int DEPTH = 16;
    localparam int IW    = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [31:0]       fetch_addr = '0;
    logic              stall = 1'b0, flush = 1'b0;
    logic [31:0]       instr_out;
    logic              instr_valid, fault;
    logic              prog_start = 1'b0, prog_valid = 1'b0, prog_last = 1'b0;
    logic [IW-1:0]     prog_base = '0;
    logic [31:0]       prog_data = '0;
    logic              loading, prog_err;
    logic [IW:0]       prog_count;

    int n_checks = 0;
    int n_fail   = 0;

    instr_mem_pipelined #(.DATA_W(32), .ADDR_W(32), .DEPTH(DEPTH), .NOP_WORD(32'h0)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_addr(fetch_addr), .stall(stall), .flush(flush),
        .instr_out(instr_out), .instr_valid(instr_valid), .fault(fault),
        .prog_start(prog_start), .prog_base(prog_base), .prog_valid(prog_valid),
        .prog_data(prog_data), .prog_last(prog_last), .loading(loading),
        .prog_err(prog_err), .prog_count(prog_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [IW-1:0] base);
        prog_start = 1'b1;
        prog_base  = base;
        step();
        prog_start = 1'b0;
    endtask

    task automatic beat(input logic [31:0] d, input logic last);
        prog_valid = 1'b1;
        prog_data  = d;
        prog_last  = last;
        step();
        prog_valid = 1'b0;
        prog_last  = 1'b0;
    endtask

    task automatic fetch(input logic [31:0] a);
        fetch_addr = a;
        step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        n_checks++; if (instr_out !== 32'h0) begin n_fail++; $display("FAIL reset_instr got %h exp 00000000", instr_out); end
        n_checks++; if ({instr_valid, fault, loading, prog_err} !== 4'b0) begin n_fail++; $display("FAIL reset_flags got %b exp 0000", {instr_valid, fault, loading, prog_err}); end
        n_checks++; if (prog_count !== 5'd0) begin n_fail++; $display("FAIL reset_count got %0d exp 0", prog_count); end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_load_fetch();
        start_load(4'd0);
        n_checks++; if (loading !== 1'b1) begin n_fail++; $display("FAIL load_enter got %b exp 1", loading); end
        beat(32'h8e120000, 1'b0);
        beat(32'h02529820, 1'b1);
        n_checks++; if (loading !== 1'b0) begin n_fail++; $display("FAIL load_exit got %b exp 0", loading); end
        n_checks++; if (prog_count !== 5'd2) begin n_fail++; $display("FAIL load_count got %0d exp 2", prog_count); end
        fetch(32'd0);
        n_checks++; if (instr_out !== 32'h8e120000 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL fetch0 got %h/%b exp 8e120000/1", instr_out, instr_valid); end
        fetch(32'd4);
        n_checks++; if (instr_out !== 32'h02529820 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL fetch4 got %h/%b exp 02529820/1", instr_out, instr_valid); end
    endtask

    task automatic test_stall_flush();
        stall = 1'b1;
        fetch_addr = 32'd0;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (instr_out !== 32'h02529820 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL stall_hold%0d got %h/%b exp 02529820/1", i, instr_out, instr_valid); end
        end
        flush = 1'b1;
        step();
        n_checks++; if (instr_out !== 32'h0 || instr_valid !== 1'b0 || fault !== 1'b0) begin n_fail++; $display("FAIL stall_flush got %h/%b/%b exp 00000000/0/0", instr_out, instr_valid, fault); end
        stall = 1'b0;
        flush = 1'b0;
        fetch(32'd0);
        n_checks++; if (instr_out !== 32'h8e120000) begin n_fail++; $display("FAIL after_flush got %h exp 8e120000", instr_out); end
    endtask

    task automatic test_overflow();
        start_load(4'(DEPTH - 2));
        beat(32'ha0a0a0a0, 1'b0);
        beat(32'ha1a1a1a1, 1'b0);
        beat(32'ha2a2a2a2, 1'b0);
        beat(32'ha3a3a3a3, 1'b1);
        n_checks++; if (prog_err !== 1'b1) begin n_fail++; $display("FAIL ovf_err got %b exp 1", prog_err); end
        n_checks++; if (prog_count !== 5'd2) begin n_fail++; $display("FAIL ovf_count got %0d exp 2", prog_count); end
        n_checks++; if (loading !== 1'b0) begin n_fail++; $display("FAIL ovf_exit got %b exp 0", loading); end
        fetch(32'(4 * (DEPTH - 2)));
        n_checks++; if (instr_out !== 32'ha0a0a0a0) begin n_fail++; $display("FAIL ovf_w0 got %h exp a0a0a0a0", instr_out); end
        fetch(32'd0);
        n_checks++; if (instr_out !== 32'h8e120000) begin n_fail++; $display("FAIL ovf_nowrap0 got %h exp 8e120000", instr_out); end
        fetch(32'd4);
        n_checks++; if (instr_out !== 32'h02529820) begin n_fail++; $display("FAIL ovf_nowrap1 got %h exp 02529820", instr_out); end
    endtask

    task automatic test_fault();
        fetch(32'h2);
        n_checks++; if (fault !== 1'b1 || instr_out !== 32'h0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL misalign got %b/%h/%b exp 1/00000000/0", fault, instr_out, instr_valid); end
        fetch(32'(4 * DEPTH));
        n_checks++; if (fault !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL oor got %b/%b exp 1/0", fault, instr_valid); end
        fetch(32'(4 * (DEPTH - 1)));
        n_checks++; if (fault !== 1'b0 || instr_out !== 32'ha1a1a1a1 || instr_valid !== 1'b1) begin n_fail++; $display("FAIL last_word got %b/%h/%b exp 0/a1a1a1a1/1", fault, instr_out, instr_valid); end
        fetch(32'h80000000);
        n_checks++; if (fault !== 1'b1) begin n_fail++; $display("FAIL oor_high got %b exp 1", fault); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_checks++; if (fault !== 1'b0) begin n_fail++; $display("FAIL flush_clears_fault got %b exp 0", fault); end
    endtask

    task automatic test_reset_midload();
        start_load(4'd4);
        beat(32'hc0c0c0c0, 1'b0);
        beat(32'hc1c1c1c1, 1'b0);
        beat(32'hc2c2c2c2, 1'b1);
        start_load(4'd4);
        beat(32'hb0b0b0b0, 1'b0);
        n_checks++; if (prog_count !== 5'd1 || loading !== 1'b1) begin n_fail++; $display("FAIL midload_pre got %0d/%b exp 1/1", prog_count, loading); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (loading !== 1'b0 || prog_count !== 5'd0 || instr_valid !== 1'b0 || instr_out !== 32'h0) begin n_fail++; $display("FAIL midload_reset got %b/%0d/%b/%h exp 0/0/0/00000000", loading, prog_count, instr_valid, instr_out); end
        step();
        rst_n = 1'b1;
        fetch(32'd16);
        n_checks++; if (instr_out !== 32'hb0b0b0b0) begin n_fail++; $display("FAIL midload_beat1 got %h exp b0b0b0b0", instr_out); end
        fetch(32'd20);
        n_checks++; if (instr_out !== 32'hc1c1c1c1) begin n_fail++; $display("FAIL midload_old got %h exp c1c1c1c1", instr_out); end
    endtask

    task automatic test_restart();
        start_load(4'd8);
        beat(32'hd0d0d0d0, 1'b0);
        prog_start = 1'b1;
        prog_base  = 4'd10;
        prog_valid = 1'b1;
        prog_data  = 32'hdeadbeef;
        step();
        prog_start = 1'b0;
        prog_valid = 1'b0;
        n_checks++; if (prog_count !== 5'd0 || loading !== 1'b1) begin n_fail++; $display("FAIL restart_count got %0d/%b exp 0/1", prog_count, loading); end
        beat(32'he0e0e0e0, 1'b0);
        beat(32'he1e1e1e1, 1'b1);
        n_checks++; if (prog_count !== 5'd2) begin n_fail++; $display("FAIL restart_final got %0d exp 2", prog_count); end
        fetch(32'd40);
        n_checks++; if (instr_out !== 32'he0e0e0e0) begin n_fail++; $display("FAIL restart_w0 got %h exp e0e0e0e0", instr_out); end
        fetch(32'd44);
        n_checks++; if (instr_out !== 32'he1e1e1e1) begin n_fail++; $display("FAIL restart_w1 got %h exp e1e1e1e1", instr_out); end
        fetch(32'd32);
        n_checks++; if (instr_out !== 32'hd0d0d0d0) begin n_fail++; $display("FAIL restart_old got %h exp d0d0d0d0", instr_out); end
    endtask

    task automatic test_run_ignores_prog();
        prog_valid = 1'b1;
        prog_data  = 32'h12345678;
        fetch(32'd0);
        prog_valid = 1'b0;
        n_checks++; if (loading !== 1'b0 || instr_out !== 32'h8e120000) begin n_fail++; $display("FAIL run_ignore got %b/%h exp 0/8e120000", loading, instr_out); end
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_stall_flush();
        test_overflow();
        test_fault();
        test_reset_midload();
        test_restart();
        test_run_ignores_prog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/instr_mem_pipelined.md
Name: instr_mem_pipelined

Overview:
Parametrised instruction memory for the pipelined MIPS core. It is the next generation of the combinational word-addressed ROM. The read is registered (1-cycle fetch latency) and honours pipeline stall and flush. Misaligned and out-of-range fetches are flagged. A streaming program-load port with a small state machine lets the bench or a boot loader fill the memory at run time without hierarchical initial blocks.

Parameters:
DATA_W, 32, instruction word width in bits
ADDR_W, 32, byte-address width of fetch_addr
DEPTH, 1024, number of words (power of two, >=2)
NOP_WORD, 32'h00000000, word driven on flush, fault or while loading

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
fetch_addr  in  ADDR_W  byte address from PC
stall  in  1  hold current output, ignore fetch_addr
flush  in  1  squash; next output is bubble
instr_out  out  DATA_W  registered instruction
instr_valid  out  1  instr_out is a real fetched instruction
fault  out  1  registered: last fetch misaligned or out of range
prog_start  in  1  pulse: enter LOAD, base word index = prog_base
prog_base  in  $clog2(DEPTH)  first word index to write
prog_valid  in  1  prog_data valid this cycle
prog_data  in  DATA_W  word to write
prog_last  in  1  qualifies final prog_valid beat
loading  out  1  state == LOAD
prog_err  out  1  sticky: a beat was dropped for overflow
prog_count  out  $clog2(DEPTH)+1  beats written in current/last load

Behaviour:
- Reset (async, rst_n=0): state=RUN, instr_out=NOP_WORD, instr_valid=0, fault=0, loading=0, prog_err=0, prog_count=0, write pointer=0. The memory array is not reset; its contents are preserved across reset.
- Word index = fetch_addr >> 2. Misaligned = fetch_addr[1:0]!=0. Out of range = index >= DEPTH.
- RUN, per rising edge, in priority order:
  - flush=1: instr_out=NOP_WORD, instr_valid=0, fault=0. Flush beats stall.
  - stall=1: all fetch outputs hold their value.
  - Misaligned or out of range: instr_out=NOP_WORD, instr_valid=0, fault=1.
  - Otherwise: instr_out=mem[index], instr_valid=1, fault=0.
- Latency: address presented in cycle N appears on instr_out after edge N+1.
- FSM has two states: RUN and LOAD.
  - RUN -> LOAD on prog_start. Write pointer=prog_base, prog_count=0, prog_err=0.
  - LOAD: each prog_valid beat writes mem[ptr]=prog_data, then ptr+1 and prog_count+1.
  - Pointer reaching DEPTH does not wrap. Further beats are dropped and set prog_err; prog_count does not increment for dropped beats.
  - LOAD -> RUN on the edge that accepts prog_valid&prog_last. This last beat is written (or dropped on overflow) before the exit.
  - prog_start while in LOAD restarts the load: pointer=prog_base, count=0, prog_err=0. A prog_valid in that same cycle is ignored.
  - prog_valid while in RUN is ignored.
- While in LOAD: instr_out=NOP_WORD, instr_valid=0, fault=0, and stall/flush/fetch are ignored. The first fetch after LOAD->RUN is an ordinary RUN fetch: an address presented in the exit cycle+1 returns the new contents on the following edge.
- loading=1 exactly while state==LOAD (registered).
- Reset mid-load returns to RUN. Words already written keep their values; prog_count and prog_err clear.
- Memory is inferred as a synchronous single-write, single-read array with no read-during-write hazard, because reads and writes are mutually exclusive by state.

Test Plan:
- Reset, then load mem[0]=32'h8e120000 and mem[1]=32'h02529820 via prog_start (base 0) and two beats (last on 2nd). Fetch 0 then 4 -> instr_out 8e120000 then 02529820 one cycle after each address, instr_valid=1, prog_count=2.
- Fetch 4 with stall=1 for 3 cycles while fetch_addr changes to 8 -> instr_out holds 02529820. stall and flush together -> next output NOP, valid=0.
- fetch_addr=32'h2 -> fault=1, instr_out=0, valid=0. fetch_addr=4*DEPTH -> fault=1. fetch_addr=4*(DEPTH-1) -> fault=0.
- prog_base=DEPTH-2 with 4 beats -> first 2 written, prog_err=1, prog_count=2. mem[0] is unchanged (no wrap) and is fetched afterwards to confirm.
- Deassert rst_n mid-load after 1 of 3 beats -> loading=0 immediately, outputs at reset values. The beat-1 word is readable after reset and beat-2 addresses hold their old contents.
- prog_start during LOAD with a new base -> count restarts at 0 and writes go to the new base.
